pcie_cpld_monitor: RTL and testbench

Receive-side completion monitor for the FPGA-master DMA read path. It consumes parsed Completion (Cpl/CplD) TLP headers and payload strobes from the PCIe RX engine, and tracks outstanding MRd tags. It accumulates the received completion count and payload size in DWs, and raises sticky malformed and data-error flags. Its outputs drive the cpld_data_size_i, cpld_malformed_i and cpld_data_err_i inputs of the read-metering (MRd throttle) stage.

---
 rtl/pcie_cpld_monitor.sv | 181 ++++++++++++++++++
 tb/tb_pcie_cpld_monitor.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_cpld_monitor.sv
// Completion monitor for the FPGA-master DMA read path: tracks outstanding MRd
// tags, judges each Cpl/CplD and accumulates good completion count and payload.
module pcie_cpld_monitor #(
  parameter int TAG_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  init_rst_i,
  input  logic                  mrd_tag_issue_i,
  input  logic [TAG_W-1:0]      mrd_tag_i,
  input  logic                  cpl_hdr_vld_i,
  input  logic                  cpl_has_data_i,
  input  logic [2:0]            cpl_status_i,
  input  logic                  cpl_ep_i,
  input  logic [9:0]            cpl_len_i,
  input  logic [11:0]           cpl_byte_cnt_i,
  input  logic [7:0]            cpl_tag_i,
  input  logic [1:0]            cpl_dw_vld_i,
  input  logic                  cpl_eof_i,
  output logic [31:0]           cpld_found_o,
  output logic [31:0]           cpld_data_size_o,
  output logic                  cpld_malformed_o,
  output logic                  cpld_data_err_o,
  output logic [2**TAG_W-1:0]   tags_pending_o,
  output logic                  busy_o
);
  localparam int         NTAG  = 2 ** TAG_W;
  localparam logic [2:0] ST_SC = 3'b000;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_CHECK} state_t;

  state_t            state;
  logic              busy;
  logic              h_data;
  logic [2:0]        h_status;
  logic              h_ep;
  logic [9:0]        h_len;
  logic [11:0]       h_bc;
  logic [7:0]        h_tag;
  logic [10:0]       dw_cnt;
  logic              dw_bad;
  logic [31:0]       found;
  logic [31:0]       data_size;
  logic              malformed;
  logic              data_err;
  logic [NTAG-1:0]   pending;

  logic [TAG_W-1:0]  tag_idx;
  logic [10:0]       eff_len;
  logic [12:0]       eff_bc;
  logic              is_last;
  logic              judge_mal;
  logic              judge_err;
  logic              retire;
  logic              good;
  logic              dup_issue;
  logic [1:0]        beat_dws;
  logic [NTAG-1:0]   pending_nxt;

  assign tag_idx = h_tag[TAG_W-1:0];

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    eff_len     = (h_len == 10'd0) ? 11'd1024 : {1'b0, h_len};
    eff_bc      = (h_bc == 12'd0) ? 13'd4096 : {1'b0, h_bc};
    is_last     = (eff_bc <= {eff_len, 2'b00});
    judge_mal   = dw_bad
                | ~pending[tag_idx]
                | ((h_tag >> TAG_W) != 8'd0)
                | (h_data & (dw_cnt != eff_len))
                | (~h_data & (h_status == ST_SC));
    judge_err   = (h_status != ST_SC) | h_ep;
    retire      = (state == S_CHECK) & ~judge_mal & is_last;
    good        = (state == S_CHECK) & ~judge_mal & ~judge_err;
    beat_dws    = {1'b0, cpl_dw_vld_i[1]} + {1'b0, cpl_dw_vld_i[0]};
    // A retire and a re-issue of the same tag in one cycle is a legal handover.
    dup_issue   = mrd_tag_issue_i & pending[mrd_tag_i]
                & ~(retire & (tag_idx == mrd_tag_i));
    pending_nxt = pending;
    if (retire)          pending_nxt[tag_idx]   = 1'b0;
    if (mrd_tag_issue_i) pending_nxt[mrd_tag_i] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst_n) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      h_data    <= 1'b0;
      h_status  <= '0;
      h_ep      <= 1'b0;
      h_len     <= '0;
      h_bc      <= '0;
      h_tag     <= '0;
      dw_cnt    <= '0;
      dw_bad    <= 1'b0;
      found     <= '0;
      data_size <= '0;
      malformed <= 1'b0;
      data_err  <= 1'b0;
      pending   <= '0;
    end else if (init_rst_i) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      h_data    <= 1'b0;
      h_status  <= '0;
      h_ep      <= 1'b0;
      h_len     <= '0;
      h_bc      <= '0;
      h_tag     <= '0;
      dw_cnt    <= '0;
      dw_bad    <= 1'b0;
      found     <= '0;
      data_size <= '0;
      malformed <= 1'b0;
      data_err  <= 1'b0;
      pending   <= '0;
    end else begin
      pending <= pending_nxt;
      if (dup_issue) malformed <= 1'b1;

      case (state)
        S_IDLE: begin
          if (cpl_hdr_vld_i) begin
            h_data   <= cpl_has_data_i;
            h_status <= cpl_status_i;
            h_ep     <= cpl_ep_i;
            h_len    <= cpl_len_i;
            h_bc     <= cpl_byte_cnt_i;
            h_tag    <= cpl_tag_i;
            dw_cnt   <= '0;
            dw_bad   <= 1'b0;
            busy     <= 1'b1;
            state    <= cpl_has_data_i ? S_DATA : S_CHECK;
          end
        end

        S_DATA: begin
          if (cpl_hdr_vld_i) begin
            // Header overran the payload: abandon this TLP, drop the new header.
            malformed <= 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end else if (cpl_dw_vld_i != 2'b00) begin
            dw_cnt <= dw_cnt + {9'd0, beat_dws};
            if (cpl_dw_vld_i == 2'b10) begin
              dw_bad    <= 1'b1;
              malformed <= 1'b1;
            end
            if (cpl_eof_i) state <= S_CHECK;
          end
        end

        S_CHECK: begin
          if (cpl_hdr_vld_i) malformed <= 1'b1;
          if (judge_mal)      malformed <= 1'b1;
          else if (judge_err) data_err  <= 1'b1;
          if (good) begin
            found <= found + 32'd1;
            if (h_data) data_size <= data_size + {21'd0, dw_cnt};
          end
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign cpld_found_o     = found;
  assign cpld_data_size_o = data_size;
  assign cpld_malformed_o = malformed;
  assign cpld_data_err_o  = data_err;
  assign tags_pending_o   = pending;
  assign busy_o           = busy;

endmodule

// File: tb/tb_pcie_cpld_monitor.sv
// Self-checking bench for pcie_cpld_monitor: a reference model pushes expected
// status to a scoreboard when each completion is driven; results are popped and compared.
module tb_pcie_cpld_monitor;
  localparam int TAG_W = 5;
  localparam int NTAG  = 2 ** TAG_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              init_rst;
  logic              mrd_tag_issue;
  logic [TAG_W-1:0]  mrd_tag;
  logic              cpl_hdr_vld;
  logic              cpl_has_data;
  logic [2:0]        cpl_status;
  logic              cpl_ep;
  logic [9:0]        cpl_len;
  logic [11:0]       cpl_byte_cnt;
  logic [7:0]        cpl_tag;
  logic [1:0]        cpl_dw_vld;
  logic              cpl_eof;
  logic [31:0]       cpld_found;
  logic [31:0]       cpld_data_size;
  logic              cpld_malformed;
  logic              cpld_data_err;
  logic [NTAG-1:0]   tags_pending;
  logic              busy;

  typedef struct packed {
    logic [31:0]     found;
    logic [31:0]     size;
    logic            mal;
    logic            err;
    logic [NTAG-1:0] pend;
  } exp_t;

  exp_t sb[$];

  logic [31:0]     m_found;
  logic [31:0]     m_size;
  logic            m_mal;
  logic            m_err;
  logic [NTAG-1:0] m_pend;

  int n_cmp = 0;
  int n_err = 0;

  pcie_cpld_monitor #(.TAG_W(TAG_W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .init_rst_i       (init_rst),
    .mrd_tag_issue_i  (mrd_tag_issue),
    .mrd_tag_i        (mrd_tag),
    .cpl_hdr_vld_i    (cpl_hdr_vld),
    .cpl_has_data_i   (cpl_has_data),
    .cpl_status_i     (cpl_status),
    .cpl_ep_i         (cpl_ep),
    .cpl_len_i        (cpl_len),
    .cpl_byte_cnt_i   (cpl_byte_cnt),
    .cpl_tag_i        (cpl_tag),
    .cpl_dw_vld_i     (cpl_dw_vld),
    .cpl_eof_i        (cpl_eof),
    .cpld_found_o     (cpld_found),
    .cpld_data_size_o (cpld_data_size),
    .cpld_malformed_o (cpld_malformed),
    .cpld_data_err_o  (cpld_data_err),
    .tags_pending_o   (tags_pending),
    .busy_o           (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_found = '0;
    m_size  = '0;
    m_mal   = 1'b0;
    m_err   = 1'b0;
    m_pend  = '0;
  endtask

  task automatic model_issue(input int t);
    if (m_pend[t]) m_mal = 1'b1;
    m_pend[t] = 1'b1;
  endtask

  task automatic check_all(input string name);
    check({name, ".found"}, cpld_found, m_found);
    check({name, ".size"},  cpld_data_size, m_size);
    check({name, ".mal"},   cpld_malformed, m_mal);
    check({name, ".err"},   cpld_data_err, m_err);
    check({name, ".pend"},  tags_pending, m_pend);
  endtask

  task automatic sb_compare(input string name);
    exp_t e;
    check({name, ".sb_depth"}, sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({name, ".found"}, cpld_found, e.found);
      check({name, ".size"},  cpld_data_size, e.size);
      check({name, ".mal"},   cpld_malformed, e.mal);
      check({name, ".err"},   cpld_data_err, e.err);
      check({name, ".pend"},  tags_pending, e.pend);
    end
  endtask

  task automatic issue(input int t);
    model_issue(t);
    mrd_tag_issue = 1'b1;
    mrd_tag       = TAG_W'(t);
    tick();
    mrd_tag_issue = 1'b0;
    check($sformatf("issue%0d.pend", t), tags_pending, m_pend);
  endtask

  task automatic init_pulse();
    init_rst = 1'b1;
    tick();
    init_rst = 1'b0;
    model_clear();
  endtask

  // Drives one completion; iss_tag >= 0 issues that tag during the judge cycle.
  task automatic send_cpl(input string name, input bit hd, input logic [2:0] st,
                          input bit ep, input logic [9:0] len, input logic [11:0] bc,
                          input logic [7:0] tag, input int ndw, input bit bad_first,
                          input int iss_tag);
    int          rem;
    int          n;
    int          eff_len;
    int          eff_bc;
    bit          mal;
    logic [31:0] prev_found;
    exp_t        e;

    cpl_hdr_vld  = 1'b1;
    cpl_has_data = hd;
    cpl_status   = st;
    cpl_ep       = ep;
    cpl_len      = len;
    cpl_byte_cnt = bc;
    cpl_tag      = tag;
    tick();
    cpl_hdr_vld  = 1'b0;

    rem = hd ? ndw : 0;
    if (hd && bad_first) begin
      cpl_dw_vld = 2'b10;
      rem--;
      cpl_eof = (rem == 0);
      tick();
    end
    while (rem > 0) begin
      if (rem >= 2) begin
        cpl_dw_vld = 2'b11;
        rem -= 2;
      end else begin
        cpl_dw_vld = 2'b01;
        rem--;
      end
      cpl_eof = (rem == 0);
      tick();
    end
    cpl_dw_vld = 2'b00;
    cpl_eof    = 1'b0;

    prev_found = m_found;
    eff_len = (len == 10'd0) ? 1024 : int'(len);
    eff_bc  = (bc == 12'd0) ? 4096 : int'(bc);
    mal = bad_first || !m_pend[tag[TAG_W-1:0]] || ((tag >> TAG_W) != 8'd0)
       || (hd && ndw != eff_len) || (!hd && st == 3'b000);
    if (mal) begin
      m_mal = 1'b1;
    end else begin
      if (st != 3'b000 || ep) m_err = 1'b1;
      else begin
        m_found = m_found + 32'd1;
        if (hd) m_size = m_size + 32'(ndw);
      end
      if (eff_bc <= eff_len * 4) m_pend[tag[TAG_W-1:0]] = 1'b0;
    end
    if (iss_tag >= 0) begin
      model_issue(iss_tag);
      mrd_tag_issue = 1'b1;
      mrd_tag       = TAG_W'(iss_tag);
    end
    e.found = m_found;
    e.size  = m_size;
    e.mal   = m_mal;
    e.err   = m_err;
    e.pend  = m_pend;
    sb.push_back(e);

    check({name, ".pre"}, cpld_found, prev_found);
    tick();
    mrd_tag_issue = 1'b0;
    n = 1;
    while (busy && n < 8) begin
      tick();
      n++;
    end
    check({name, ".lat"}, n, 1);
    sb_compare(name);
  endtask

  initial begin
    rst_n         = 1'b0;
    init_rst      = 1'b0;
    mrd_tag_issue = 1'b0;
    mrd_tag       = '0;
    cpl_hdr_vld   = 1'b0;
    cpl_has_data  = 1'b0;
    cpl_status    = '0;
    cpl_ep        = 1'b0;
    cpl_len       = '0;
    cpl_byte_cnt  = '0;
    cpl_tag       = '0;
    cpl_dw_vld    = '0;
    cpl_eof       = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    check_all("reset");
    check("reset.busy", busy, 0);

    issue(3);
    send_cpl("good", 1, 3'b000, 0, 10'd16, 12'd64, 8'd3, 16, 0, -1);

    issue(1);
    send_cpl("split1", 1, 3'b000, 0, 10'd32, 12'd256, 8'd1, 32, 0, -1);
    send_cpl("split2", 1, 3'b000, 0, 10'd32, 12'd128, 8'd1, 32, 0, -1);

    issue(2);
    send_cpl("ca", 0, 3'b100, 0, 10'd1, 12'd4, 8'd2, 0, 0, -1);

    issue(4);
    send_cpl("len0", 1, 3'b000, 0, 10'd0, 12'd0, 8'd4, 1024, 0, -1);

    force dut.data_size = 32'hFFFF_FFF8;
    tick();
    release dut.data_size;
    m_size = 32'hFFFF_FFF8;
    check("wrap.preload", cpld_data_size, m_size);
    issue(6);
    send_cpl("wrap", 1, 3'b000, 0, 10'd16, 12'd64, 8'd6, 16, 0, -1);
    check("wrap.value", cpld_data_size, 32'd8);

    issue(5);
    send_cpl("same5", 1, 3'b000, 0, 10'd2, 12'd8, 8'd5, 2, 0, 5);
    check("same5.bit", tags_pending[5], 1);

    // init_rst_i in the middle of a payload
    issue(10);
    cpl_hdr_vld  = 1'b1;
    cpl_has_data = 1'b1;
    cpl_status   = 3'b000;
    cpl_ep       = 1'b0;
    cpl_len      = 10'd8;
    cpl_byte_cnt = 12'd32;
    cpl_tag      = 8'd10;
    tick();
    cpl_hdr_vld = 1'b0;
    cpl_dw_vld  = 2'b11;
    repeat (2) tick();
    init_rst = 1'b1;
    tick();
    init_rst = 1'b0;
    model_clear();
    check_all("init");
    check("init.busy", busy, 0);
    tick();
    cpl_eof = 1'b1;
    tick();
    cpl_dw_vld = 2'b00;
    cpl_eof    = 1'b0;
    tick();
    check("init_tail.busy", busy, 0);
    check_all("init_tail");

    init_pulse();
    issue(11);
    send_cpl("lenmis", 1, 3'b000, 0, 10'd4, 12'd16, 8'd11, 3, 0, -1);
    tick();
    check("lenmis.sticky", cpld_malformed, 1);

    init_pulse();
    send_cpl("tag7", 1, 3'b000, 0, 10'd1, 12'd4, 8'd7, 1, 0, -1);

    init_pulse();
    issue(3);
    send_cpl("hitag", 1, 3'b000, 0, 10'd1, 12'd4, 8'h23, 1, 0, -1);

    init_pulse();
    issue(12);
    send_cpl("dw10", 1, 3'b000, 0, 10'd2, 12'd8, 8'd12, 2, 1, -1);

    init_pulse();
    issue(13);
    send_cpl("cpl_sc", 0, 3'b000, 0, 10'd1, 12'd4, 8'd13, 0, 0, -1);

    init_pulse();
    issue(0);
    issue(0);
    check_all("dup");

    // Header arriving during payload: TLP abandoned, new header dropped.
    init_pulse();
    issue(9);
    cpl_hdr_vld  = 1'b1;
    cpl_has_data = 1'b1;
    cpl_status   = 3'b000;
    cpl_len      = 10'd4;
    cpl_byte_cnt = 12'd16;
    cpl_tag      = 8'd9;
    tick();
    cpl_hdr_vld = 1'b0;
    cpl_dw_vld  = 2'b11;
    tick();
    cpl_dw_vld  = 2'b00;
    cpl_hdr_vld = 1'b1;
    tick();
    cpl_hdr_vld = 1'b0;
    m_mal = 1'b1;
    check("hdr_data.busy", busy, 0);
    check_all("hdr_data");
    cpl_dw_vld = 2'b11;
    cpl_eof    = 1'b1;
    tick();
    cpl_dw_vld = 2'b00;
    cpl_eof    = 1'b0;
    tick();
    check("hdr_data_tail.busy", busy, 0);
    check_all("hdr_data_tail");

    // Header arriving in the judge cycle is dropped; current TLP still judged.
    init_pulse();
    issue(14);
    cpl_hdr_vld  = 1'b1;
    cpl_has_data = 1'b0;
    cpl_status   = 3'b100;
    cpl_len      = 10'd1;
    cpl_byte_cnt = 12'd4;
    cpl_tag      = 8'd14;
    tick();
    tick();
    cpl_hdr_vld = 1'b0;
    m_mal = 1'b1;
    m_err = 1'b1;
    m_pend[14] = 1'b0;
    check("hdr_chk.busy", busy, 0);
    check_all("hdr_chk");
    tick();
    check("hdr_chk_after.busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
